// File: rtl/speed_pattern_gen_if.sv
// Button/mode inputs and pattern outputs of one speed_pattern_gen channel.
interface speed_pattern_gen_if #(
   parameter int WIDTH        = 8,
   parameter int SPEED_LEVELS = 8
);
   localparam int SPEED_W = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1;

   logic               btn_pause;
   logic               btn_faster;
   logic               btn_slower;
   logic [1:0]         mode;
   logic [WIDTH-1:0]   pattern;
   logic               running;
   logic [SPEED_W-1:0] speed;
   logic               step_pulse;

   modport master (
      output btn_pause, btn_faster, btn_slower, mode,
      input  pattern, running, speed, step_pulse
   );

   modport slave (
      input  btn_pause, btn_faster, btn_slower, mode,
      output pattern, running, speed, step_pulse
   );
endinterface

// File: rtl/speed_pattern_gen.sv
// Button-driven pattern generator: debounced pause/faster/slower buttons,
// power-of-two speed ladder and four selectable WIDTH-bit output patterns.
module speed_pattern_gen #(
   parameter int WIDTH        = 8,
   parameter int TICK_DIV     = 12_500_000,
   parameter int SPEED_LEVELS = 8,
   parameter int SPEED_RESET  = 3,
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic               clk,
   input  logic               rst,
   speed_pattern_gen_if.slave bus
);
   localparam int     SPEED_W    = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1;
   localparam longint MAX_PERIOD = longint'(TICK_DIV) << (SPEED_LEVELS - 1);
   localparam int     PRE_W      = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
   localparam int     DB_W       = $clog2(DEBOUNCE_CYC + 1);

   localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(SPEED_LEVELS - 1);
   localparam logic [SPEED_W-1:0] SPEED_INI = SPEED_W'(SPEED_RESET);

   // Speed index after faster/slower events; opposing events cancel, ends saturate.
   function automatic logic [SPEED_W-1:0] sat_speed(input logic [SPEED_W-1:0] s,
                                                     input logic up, input logic dn);
      logic [SPEED_W-1:0] r;
      r = s;
      if (up && !dn && (s != SPEED_MAX))
         r = s + SPEED_W'(1);
      else if (dn && !up && (s != '0))
         r = s - SPEED_W'(1);
      return r;
   endfunction

   // Rotate and bounce start from a single lit LSB; binary and Gray start from zero.
   function automatic logic [WIDTH-1:0] seed_pattern(input logic [1:0] m);
      return m[1] ? '0 : WIDTH'(1);
   endfunction

   // Button bit order: 0 pause, 1 faster, 2 slower
   logic [2:0]       btn_raw;
   logic [2:0]       sync_p0;
   logic [2:0]       sync_p1;
   logic [2:0]       db_lvl;
   logic [2:0]       db_lvl_d;
   logic [DB_W-1:0]  db_cnt [3];
   logic [2:0]       btn_ev;

   logic [1:0]         mode_q,    mode_n;
   logic [WIDTH-1:0]   pattern_q, pattern_n;
   logic [WIDTH-1:0]   cnt_q,     cnt_n;
   logic [WIDTH-1:0]   cnt_inc;
   logic               dir_q,     dir_n;
   logic               running_q, running_n;
   logic [SPEED_W-1:0] speed_q,   speed_n;
   logic [PRE_W-1:0]   pre_q,     pre_n;
   logic [PRE_W-1:0]   period_m1;
   logic               step_q,    step_n;
   logic               mode_chg;

   assign btn_raw  = {bus.btn_slower, bus.btn_faster, bus.btn_pause};
   assign btn_ev   = db_lvl & ~db_lvl_d;
   assign mode_chg = (bus.mode != mode_q);

   // Synchronise each raw button, debounce it, and keep the previous level for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         db_lvl   <= '0;
         db_lvl_d <= '0;
         for (int i = 0; i < 3; i++)
            db_cnt[i] <= '0;
      end else begin
         sync_p0  <= btn_raw;
         sync_p1  <= sync_p0;
         db_lvl_d <= db_lvl;
         for (int i = 0; i < 3; i++) begin
            if (sync_p1[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_lvl[i] <= sync_p1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Next state: mode reload beats a speed-change clear, which beats a normal prescaler step.
   always_comb begin
      speed_n   = sat_speed(speed_q, btn_ev[2], btn_ev[1]);
      running_n = running_q ^ btn_ev[0];
      period_m1 = PRE_W'((longint'(TICK_DIV) << speed_q) - 64'sd1);
      cnt_inc   = cnt_q + WIDTH'(1);
      mode_n    = mode_q;
      pattern_n = pattern_q;
      cnt_n     = cnt_q;
      dir_n     = dir_q;
      pre_n     = pre_q;
      step_n    = 1'b0;
      if (mode_chg) begin
         mode_n    = bus.mode;
         pattern_n = seed_pattern(bus.mode);
         cnt_n     = '0;
         dir_n     = 1'b0;
         pre_n     = '0;
      end else if (speed_n != speed_q) begin
         pre_n = '0;
      end else if (running_q) begin
         if (pre_q == period_m1) begin
            pre_n  = '0;
            step_n = 1'b1;
            case (mode_q)
               2'd0: pattern_n = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
               2'd1: begin
                  if (!dir_q) begin
                     if (pattern_q[WIDTH-1]) begin
                        dir_n     = 1'b1;
                        pattern_n = pattern_q >> 1;
                     end else begin
                        pattern_n = pattern_q << 1;
                     end
                  end else begin
                     if (pattern_q[0]) begin
                        dir_n     = 1'b0;
                        pattern_n = pattern_q << 1;
                     end else begin
                        pattern_n = pattern_q >> 1;
                     end
                  end
               end
               2'd2: begin
                  cnt_n     = cnt_inc;
                  pattern_n = cnt_inc;
               end
               default: begin
                  cnt_n     = cnt_inc;
                  pattern_n = cnt_inc ^ (cnt_inc >> 1);
               end
            endcase
         end else begin
            pre_n = pre_q + PRE_W'(1);
         end
      end
   end

   // State and output registers; reset overrides any pending event or step.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= 2'd0;
         pattern_q <= WIDTH'(1);
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         running_q <= 1'b0;
         speed_q   <= SPEED_INI;
         pre_q     <= '0;
         step_q    <= 1'b0;
      end else begin
         mode_q    <= mode_n;
         pattern_q <= pattern_n;
         cnt_q     <= cnt_n;
         dir_q     <= dir_n;
         running_q <= running_n;
         speed_q   <= speed_n;
         pre_q     <= pre_n;
         step_q    <= step_n;
      end
   end

   assign bus.pattern    = pattern_q;
   assign bus.running    = running_q;
   assign bus.speed      = speed_q;
   assign bus.step_pulse = step_q;
endmodule
